// File: rtl/hs_io_port_pkg.sv
// Shared types and default sizing for the buffered four-phase I/O port.
// Both FIFOs and the port top import this package.
package hs_io_port_pkg;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_DEPTH       = 4;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic {
      RX_IDLE,
      RX_ACK
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_STROBE,
      TX_RELEASE
   } tx_state_t;

endpackage

// File: rtl/hs_sync_fifo.sv
// Show-ahead synchronous FIFO with registered count/full/empty.
// Pushes while full and pops while empty are ignored.
module hs_sync_fifo
   import hs_io_port_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW-1:0]    head_ptr;
   logic [CW-1:0]    count_next;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok) begin
         count_next = count + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count - CW'(1);
      end
   end

   // When empty, look at the slot just popped so the head holds its last value.
   assign head_ptr = empty ? (rptr - PW'(1)) : rptr;
   assign head     = mem[head_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (push_ok) begin
            mem[wptr] <= push_data;
            wptr      <= wptr + PW'(1);
         end
         if (pop_ok) begin
            rptr <= rptr + PW'(1);
         end
         count <= count_next;
         full  <= (count_next == FULL_COUNT);
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/hs_io_port.sv
// Buffered processor I/O port: core-side FIFO read/write, external-side
// four-phase ready/acknowledge handshake in each direction.
module hs_io_port
   import hs_io_port_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic                       inDataReady,
   output logic                       inACK,
   output logic [WIDTH-1:0]           out,
   output logic                       outDataReady,
   input  logic                       outACK,
   input  logic                       cpu_wr,
   input  logic [WIDTH-1:0]           cpu_wdata,
   output logic                       tx_full,
   input  logic                       cpu_rd,
   output logic [WIDTH-1:0]           cpu_rdata,
   output logic                       rx_empty,
   output logic [$clog2(DEPTH+1)-1:0] rx_count,
   output logic [$clog2(DEPTH+1)-1:0] tx_count,
   output logic                       tx_overflow
);

   logic [SYNC_STAGES-1:0] ready_sync;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ready_s;
   logic                   ack_s;

   rx_state_t              rx_state;
   tx_state_t              tx_state;

   logic                   rx_full;
   logic                   rx_push;
   logic                   tx_empty;
   logic                   tx_pop;
   logic [WIDTH-1:0]       tx_head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_sync <= '0;
         ack_sync   <= '0;
      end else begin
         ready_sync[0] <= inDataReady;
         ack_sync[0]   <= outACK;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ready_sync[i] <= ready_sync[i-1];
            ack_sync[i]   <= ack_sync[i-1];
         end
      end
   end

   assign ready_s = ready_sync[SYNC_STAGES-1];
   assign ack_s   = ack_sync[SYNC_STAGES-1];

   // Full/empty come from registered counts, so a blocked push retries next cycle.
   assign rx_push = (rx_state == RX_IDLE) && ready_s && !rx_full;
   assign tx_pop  = (tx_state == TX_IDLE) && !tx_empty;

   hs_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (rx_push),
      .push_data (in),
      .pop       (cpu_rd),
      .head      (cpu_rdata),
      .count     (rx_count),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   hs_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (cpu_wr),
      .push_data (cpu_wdata),
      .pop       (tx_pop),
      .head      (tx_head),
      .count     (tx_count),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         inACK    <= 1'b0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (ready_s && !rx_full) begin
                  rx_state <= RX_ACK;
                  inACK    <= 1'b1;
               end
            end
            RX_ACK: begin
               if (!ready_s) begin
                  rx_state <= RX_IDLE;
                  inACK    <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state     <= TX_IDLE;
         outDataReady <= 1'b0;
         out          <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (!tx_empty) begin
                  tx_state     <= TX_STROBE;
                  out          <= tx_head;
                  outDataReady <= 1'b1;
               end
            end
            TX_STROBE: begin
               if (ack_s) begin
                  tx_state     <= TX_RELEASE;
                  outDataReady <= 1'b0;
               end
            end
            TX_RELEASE: begin
               if (!ack_s) begin
                  tx_state <= TX_IDLE;
               end
            end
            default: begin
               tx_state     <= TX_IDLE;
               outDataReady <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_overflow <= 1'b0;
      end else if (cpu_wr && tx_full) begin
         tx_overflow <= 1'b1;
      end
   end

endmodule

// File: doc/hs_io_port.md
# hs_io_port

Parametrised, buffered I/O port between the processor core and the external four-phase ready/acknowledge byte interface. It replaces the core's fixed 8-bit, unbuffered handshake with these features:
- configurable data width;
- independent RX and TX FIFOs;
- synchronisers on the asynchronous handshake inputs.

The core side is a simple FIFO read/write port. The external side keeps the existing `in`/`inDataReady`/`inACK` and `out`/`outDataReady`/`outACK` protocol.

## Interface
Parameters:
- WIDTH, 8, data width of both directions.
- DEPTH, 4, entries per FIFO. Must be a power of two, ≥2.
- SYNC_STAGES, 2, flop stages on `inDataReady` and `outACK`. Must be ≥1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- in  in  WIDTH  external input data. Held stable by the sender while `inDataReady`=1.
- inDataReady  in  1  external input strobe (asynchronous).
- inACK  out  1  input acknowledge.
- out  out  WIDTH  external output data.
- outDataReady  out  1  output strobe.
- outACK  in  1  external output acknowledge (asynchronous).
- cpu_wr  in  1  push `cpu_wdata` into TX FIFO.
- cpu_wdata  in  WIDTH  TX write data.
- tx_full  out  1  TX FIFO full.
- cpu_rd  in  1  pop RX FIFO.
- cpu_rdata  out  WIDTH  RX FIFO head (show-ahead).
- rx_empty  out  1  RX FIFO empty.
- rx_count, tx_count  out  $clog2(DEPTH+1)  occupancy.
- tx_overflow  out  1  sticky. Set by `cpu_wr` while `tx_full`. Cleared only by reset.

## Operation
- Reset values:
  - `inACK`=0, `outDataReady`=0, `out`=0.
  - Both FIFOs empty: `rx_empty`=1, `tx_full`=0, counts 0.
  - `tx_overflow`=0, `cpu_rdata`=0.
  - Both FSMs in IDLE.
  - Synchroniser flops cleared.
- RX FSM (states RX_IDLE, RX_ACK):
  - RX_IDLE → RX_ACK when synced `inDataReady`=1 and RX not full (registered count < DEPTH). On that edge: capture `in` into the FIFO and set `inACK`=1.
  - RX_ACK → RX_IDLE when synced `inDataReady`=0. On that edge: `inACK`=0.
  - RX full: the FSM stays in RX_IDLE with `inACK`=0 (back-pressure). No data is lost.
- TX FSM (states TX_IDLE, TX_STROBE, TX_RELEASE):
  - TX_IDLE → TX_STROBE when TX not empty. On that edge: pop the head into the `out` register and set `outDataReady`=1.
  - TX_STROBE → TX_RELEASE when synced `outACK`=1. On that edge: `outDataReady`=0. `out` holds its value.
  - TX_RELEASE → TX_IDLE when synced `outACK`=0.
- CPU side:
  - `cpu_rdata` = RX head whenever `rx_empty`=0. It holds the last value otherwise.
  - `cpu_rd` on empty is ignored.
  - `cpu_wr` on full is dropped and sets `tx_overflow`.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leaves the count unchanged.
  - Full/empty decisions use the registered count from before the cycle. A push blocked by full retries the cycle after a pop; a `cpu_wr` arriving while full, in the same cycle as a TX pop, is still dropped.
- Pointers wrap modulo DEPTH. Counts saturate at neither end; they are exact because over- and under-flow operations are blocked.
- Reset mid-handshake: reset forces `inACK`/`outDataReady` low immediately (asynchronous), which aborts the handshake. A TX word popped but not yet acknowledged is lost.

## Timing
- Synchroniser latency: an external edge is seen by the FSM SYNC_STAGES cycles after the first sampling edge.
- Input handshake, `inDataReady` rising before edge k:
  - `inACK` rises after edge k+SYNC_STAGES.
  - `rx_empty` falls in the same cycle as `inACK` rises.
  - `inACK` falls SYNC_STAGES+1 edges after `inDataReady` falls.
- Output handshake, `cpu_wr` at edge k on an empty TX FIFO:
  - `tx_count` is 1 after edge k.
  - `outDataReady` rises after edge k+1.
  - Minimum handshake period is 2·SYNC_STAGES+3 cycles per word.
- CPU read: `cpu_rdata` and `rx_count` update on the edge where `cpu_rd` is sampled. There is no read latency.
- All outputs are registered, except `cpu_rdata`, which is a FIFO-storage mux on the registered read pointer.

## Structure
- Package `hs_io_port_pkg`:
  - `rx_state_t`/`tx_state_t` enums.
  - Default WIDTH/DEPTH/SYNC_STAGES constants.
- Sub-module `hs_sync_fifo` (WIDTH, DEPTH): show-ahead FIFO with count/full/empty. Instantiated twice.
- Synchronisers: a parametrised shift register inside `hs_io_port`. No separate module.

## Test plan
- RX single: drive `in`=8'hA5 with `inDataReady`=1, release on `inACK`.
  - `inACK` high 2 cycles after sync; `rx_count`=1; `cpu_rdata`=A5.
  - `cpu_rd` pulse → `rx_empty`=1.
- RX back-pressure: send 5 words (01..05) with DEPTH=4 and no reads.
  - First 4 are acknowledged; `inACK` stays 0 on word 5.
  - One `cpu_rd` → word 05 is acknowledged; reads return 02,03,04,05.
- TX stream: write 11,22,33 back-to-back; the external responder acks each strobe after 3 cycles.
  - `out` shows 11,22,33 in order, one strobe per word.
  - `tx_count` returns to 0.
- TX overflow: stall `outACK`=0, write 5 words.
  - `tx_full`=1 after 4 accepted plus 1 popped to `out`.
  - A further write sets `tx_overflow` and leaves `tx_count` unchanged.
- Simultaneous: RX FIFO at count 2, `cpu_rd` on the same edge as an RX push.
  - `rx_count` stays 2; data order is preserved.
- Reset mid-handshake: assert reset while `outDataReady`=1 and `inACK`=1.
  - Both drop without a clock edge.
  - All counts are 0, FSMs are IDLE, and `tx_overflow`=0.
